// File: rtl/edge_detect_pkg.sv
// Shared types for the rising-edge detector: state encoding and idle tick level.
package edge_detect_pkg;

    typedef enum logic {
        ZERO = 1'b0,
        ONE  = 1'b1
    } edge_state_t;

    localparam logic TICK_IDLE = 1'b0;

endpackage : edge_detect_pkg

// File: rtl/edge_detect_mealy.sv
// Rising-edge detector as a 2-state Mealy FSM; tick is combinational and
// stays high from the level rise until the next clock edge updates the state.
module edge_detect_mealy
    import edge_detect_pkg::*;
(
    input  logic clk_amisha,
    input  logic reset_amisha,
    input  logic level_amisha,
    output logic tick_amisha
);

    edge_state_t state_q;
    edge_state_t state_d;

    // State register: remembers whether the last sampled level was high.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state_q <= ZERO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ZERO;
        case (state_q)
            ZERO:    state_d = level_amisha ? ONE : ZERO;
            ONE:     state_d = level_amisha ? ONE : ZERO;
            default: state_d = ZERO;
        endcase
    end

    // Tick is gated by reset so a held level only fires once reset is released.
    always_comb begin
        tick_amisha = TICK_IDLE;
        if (!reset_amisha && (state_q == ZERO) && level_amisha) begin
            tick_amisha = 1'b1;
        end
    end

endmodule : edge_detect_mealy

// File: tb/tb_edge_detect_mealy.sv
// Scoreboard bench for edge_detect_mealy: stimulus pushes expected tick values,
// a monitor pops and compares them mid-cycle on the falling clock edge.
module tb_edge_detect_mealy;

    logic clk_amisha;
    logic reset_amisha;
    logic level_amisha;
    logic tick_amisha;

    edge_detect_mealy dut (
        .clk_amisha   (clk_amisha),
        .reset_amisha (reset_amisha),
        .level_amisha (level_amisha),
        .tick_amisha  (tick_amisha)
    );

    // 100 ns period, first rising edge at 50 ns.
    initial begin
        clk_amisha = 1'b0;
        forever #50 clk_amisha = ~clk_amisha;
    end

    typedef struct {
        logic  tick;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model: the level last seen at a clock edge outside reset
    // (reset forgets the history, so a held high counts as a new edge).
    logic seen_high;
    logic cur_rst;
    logic cur_lvl;

    // One clock cycle: account for the edge, then drive new inputs 10 ns later.
    task automatic cycle(input logic r, input logic l, input string name);
        exp_t e;
        @(posedge clk_amisha);
        if (cur_rst) seen_high = 1'b0;
        else         seen_high = cur_lvl;
        #10;
        reset_amisha = r;
        level_amisha = l;
        cur_rst      = r;
        cur_lvl      = l;
        if (r) seen_high = 1'b0;
        e.tick = (!r && l && !seen_high) ? 1'b1 : 1'b0;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT tick halfway through each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_amisha);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (tick_amisha !== e.tick) begin
                    n_fails++;
                    $display("FAIL %s @%0t: tick got %b expected %b",
                             e.name, $time, tick_amisha, e.tick);
                end
            end
        end
    end

    initial begin
        reset_amisha = 1'b1;
        level_amisha = 1'b0;
        cur_rst      = 1'b1;
        cur_lvl      = 1'b0;
        seen_high    = 1'b0;

        cycle(1'b1, 1'b0, "reset_hold");
        cycle(1'b1, 1'b1, "reset_gates_level");
        cycle(1'b0, 1'b0, "idle_low0");
        cycle(1'b0, 1'b0, "idle_low1");
        cycle(1'b0, 1'b1, "rise");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, "held_high");
        cycle(1'b0, 1'b0, "rearm_low");
        cycle(1'b0, 1'b1, "rearm_rise");
        cycle(1'b0, 1'b1, "rearm_end");
        cycle(1'b1, 1'b1, "reset_mid_one");
        cycle(1'b1, 1'b1, "reset_mid_one_hold");
        cycle(1'b0, 1'b1, "release_level_high");
        cycle(1'b0, 1'b1, "release_tick_ends");
        cycle(1'b0, 1'b0, "fall");
        cycle(1'b0, 1'b0, "low_again");

        for (int i = 0; i < 300; i++) begin
            logic r;
            logic l;
            r = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
            l = 1'(($urandom() >> 3) & 32'd1);
            cycle(r, l, "random");
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_amisha);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_edge_detect_mealy
